// File: rtl/subline_highlighter_pkg.sv
// Shared constants and types for the subline highlighter slice.
package subline_highlighter_pkg;

  // Default glyph geometry used by the lyric display pipeline
  localparam int DEF_CHAR_H = 8;
  localparam int DEF_CHAR_W = 6;
  localparam int DEF_CPSBLN = 16;

  // Ping-pong bank selector
  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_t;

  // Columns in one subline, which is also the depth of one buffer bank
  function automatic int line_cols(input int cpsbln, input int char_w);
    return cpsbln * char_w;
  endfunction

endpackage

// File: rtl/subline_highlighter_col_bank_ram.sv
// Two-bank column store: one write port, one registered read port, address = {bank, ptr}.
module col_bank_ram
  import subline_highlighter_pkg::*;
#(
  parameter int DATA_W = DEF_CHAR_H,
  parameter int PW     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [PW:0]       wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [PW:0]       rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**(PW+1)];

  // Column storage is not reset; the full flags decide what is meaningful
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Synchronous read with cleared output so the display sees zeros when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/subline_highlighter.sv
// Buffers sublines in a ping-pong column store, rescans the active one with highlight tags
// and swaps banks once the singer has passed every column.
module subline_highlighter
  import subline_highlighter_pkg::*;
#(
  parameter int CHAR_H = DEF_CHAR_H,
  parameter int CHAR_W = DEF_CHAR_W,
  parameter int CPSBLN = DEF_CPSBLN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CHAR_H-1:0] in_col,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              beat,
  output logic [CHAR_H-1:0] out_col,
  output logic              out_hl,
  output logic              out_valid,
  output logic              out_sof,
  output logic              line_done,
  output logic              underrun
);

  localparam int LINE_COLS = line_cols(CPSBLN, CHAR_W);
  localparam int PW = $clog2(LINE_COLS + 1);
  localparam logic [PW-1:0] LAST_COL = PW'(LINE_COLS - 1);
  localparam logic [PW-1:0] ALL_HL   = PW'(LINE_COLS);

  logic [PW-1:0] wptr, rptr, hl_pos;
  bank_t         wbank, rbank;
  logic [1:0]    full;
  logic          rd_active;
  logic          transfer, startup, pass_end, do_swap, do_under;

  // Decode the handshake, startup and end-of-pass events for this cycle
  always_comb begin
    in_ready = ~full[wbank];
    transfer = in_valid & in_ready;
    startup  = ~rd_active & full[BANK0];
    pass_end = rd_active && (rptr == LAST_COL);
    do_swap  = pass_end && (hl_pos == ALL_HL) && full[wbank];
    do_under = pass_end && (hl_pos == ALL_HL) && !full[wbank];
  end

  // Write pointer walks the write bank and wraps after the last column
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wptr <= '0;
    else if (transfer) wptr <= (wptr == LAST_COL) ? '0 : wptr + 1'b1;
  end

  // Full flags: set by the last write of a bank, cleared when that bank is released by a swap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= '0;
    end else begin
      if (transfer && (wptr == LAST_COL)) full[wbank] <= 1'b1;
      if (do_swap) full[rbank] <= 1'b0;
    end
  end

  // Bank roles: first full bank starts the display, afterwards roles exchange on each swap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbank <= BANK0;
      rbank <= BANK0;
    end else if (startup) begin
      rbank <= BANK0;
      wbank <= BANK1;
    end else if (do_swap) begin
      rbank <= wbank;
      wbank <= rbank;
    end
  end

  // Read scanner runs continuously over the display bank once started
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_active <= 1'b0;
      rptr      <= '0;
    end else if (startup) begin
      rd_active <= 1'b1;
      rptr      <= '0;
    end else if (rd_active) begin
      rptr <= (rptr == LAST_COL) ? '0 : rptr + 1'b1;
    end
  end

  // Highlight position saturates at a full line; a swap restarts it and drops any coincident beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hl_pos <= '0;
    else if (do_swap) hl_pos <= '0;
    else if (beat && (hl_pos != ALL_HL)) hl_pos <= hl_pos + 1'b1;
  end

  // Tags and pulses are registered alongside the RAM read so they line up with out_col
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_hl    <= 1'b0;
      out_sof   <= 1'b0;
      line_done <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      out_valid <= rd_active;
      out_hl    <= rd_active && (rptr < hl_pos);
      out_sof   <= rd_active && (rptr == '0);
      line_done <= do_swap;
      underrun  <= do_under;
    end
  end

  col_bank_ram #(
    .DATA_W (CHAR_H),
    .PW     (PW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (transfer),
    .wr_addr ({wbank, wptr}),
    .wr_data (in_col),
    .rd_en   (rd_active),
    .rd_addr ({rbank, rptr}),
    .rd_data (out_col)
  );

endmodule
